// File: rtl/unpacked_repeat_accumulate_buffer.sv
// Repeat-accumulate buffer.
// Takes REPEAT back-to-back passes of SIZE beats and sums them per lane and
// per position. It then drains one SIZE-beat block of signed sums.
// Input and output never transfer in the same cycle:
//   - ACCUM only accepts input.
//   - DRAIN only presents output.
module unpacked_repeat_accumulate_buffer #(
   parameter int IN_WIDTH  = 8,
   parameter int IN_NUM    = 1,
   parameter int REPEAT    = 2,
   parameter int SIZE      = 4,
   parameter int OUT_WIDTH = IN_WIDTH + $clog2(REPEAT)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [IN_WIDTH-1:0]  in_data [IN_NUM],
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [OUT_WIDTH-1:0] out_data [IN_NUM],
   output logic                 out_valid,
   input  logic                 out_ready
);

   // Counters keep at least one bit so REPEAT = 1 or SIZE = 1 stay legal.
   localparam int ADDR_W = (SIZE   > 1) ? $clog2(SIZE)   : 1;
   localparam int PASS_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;

   typedef enum logic {
      ACCUM = 1'b0,
      DRAIN = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
   logic [PASS_W-1:0]   pass_q, pass_d;
   logic                in_ready_q, in_ready_d;
   logic                out_valid_q, out_valid_d;
   logic [OUT_WIDTH-1:0] store_q  [SIZE][IN_NUM];
   logic [OUT_WIDTH-1:0] wr_val_d [IN_NUM];
   logic                in_fire;
   logic                out_fire;

   // Sign-extend one input lane to the accumulator width.
   function automatic logic [OUT_WIDTH-1:0] sext(input logic [IN_WIDTH-1:0] v);
      return OUT_WIDTH'($signed(v));
   endfunction

   assign in_fire   = in_valid  & in_ready_q;
   assign out_fire  = out_valid_q & out_ready;
   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;

   // Next-state logic for the FSM, address counters and pass counter.
   // The handshake flags are decoded from the next state, so they are registered.
   always_comb begin
      state_d   = state_q;
      wr_addr_d = wr_addr_q;
      rd_addr_d = rd_addr_q;
      pass_d    = pass_q;
      case (state_q)
         ACCUM: begin
            if (in_fire) begin
               if (wr_addr_q == ADDR_W'(SIZE - 1)) begin
                  wr_addr_d = {ADDR_W{1'b0}};
                  if (pass_q == PASS_W'(REPEAT - 1)) begin
                     pass_d  = {PASS_W{1'b0}};
                     state_d = DRAIN;
                  end else begin
                     pass_d = pass_q + PASS_W'(1);
                  end
               end else begin
                  wr_addr_d = wr_addr_q + ADDR_W'(1);
               end
            end else begin
               wr_addr_d = wr_addr_q;
            end
         end
         DRAIN: begin
            if (out_fire) begin
               if (rd_addr_q == ADDR_W'(SIZE - 1)) begin
                  rd_addr_d = {ADDR_W{1'b0}};
                  state_d   = ACCUM;
               end else begin
                  rd_addr_d = rd_addr_q + ADDR_W'(1);
               end
            end else begin
               rd_addr_d = rd_addr_q;
            end
         end
         default: begin
            state_d = ACCUM;
         end
      endcase
      in_ready_d  = (state_d == ACCUM);
      out_valid_d = (state_d == DRAIN);
   end

   // Value to write per lane: pass 0 overwrites, later passes accumulate.
   always_comb begin
      for (int l = 0; l < IN_NUM; l++) begin
         wr_val_d[l] = (pass_q == PASS_W'(0)) ? sext(in_data[l])
                                              : store_q[wr_addr_q][l] + sext(in_data[l]);
      end
   end

   // Control registers; reset discards any partial block.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ACCUM;
         wr_addr_q   <= {ADDR_W{1'b0}};
         rd_addr_q   <= {ADDR_W{1'b0}};
         pass_q      <= {PASS_W{1'b0}};
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_addr_q   <= wr_addr_d;
         rd_addr_q   <= rd_addr_d;
         pass_q      <= pass_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Accumulator store.
   // It needs no reset: the first pass always overwrites every position.
   always_ff @(posedge clk) begin
      if (in_fire) begin
         for (int l = 0; l < IN_NUM; l++) begin
            store_q[wr_addr_q][l] <= wr_val_d[l];
         end
      end
   end

   // Present the current drain position; it holds while rd_addr is stalled.
   always_comb begin
      for (int l = 0; l < IN_NUM; l++) begin
         out_data[l] = store_q[rd_addr_q][l];
      end
   end

endmodule

// File: tb/tb_unpacked_repeat_accumulate_buffer.sv
// Scoreboard bench for unpacked_repeat_accumulate_buffer.
// Instance A: REPEAT=2, runs the directed cases.
// Instance B: REPEAT=3, runs the randomized gap case.
module tb_unpacked_repeat_accumulate_buffer;

   localparam int S    = 4;
   localparam int OW_A = 9;
   localparam int OW_B = 10;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_data [2];
   logic       in_valid_a, in_ready_a, out_valid_a, out_ready_a;
   logic       in_valid_b, in_ready_b, out_valid_b, out_ready_b;
   logic [OW_A-1:0] out_data_a [2];
   logic [OW_B-1:0] out_data_b [2];

   int checks   = 0;
   int failures = 0;
   logic [63:0] q_a[$];
   logic [63:0] q_b[$];
   int  pat [12][2];
   bit  gaps;
   bit  rand_rdy;
   bit  hold_rdy;

   always #5 clk = ~clk;

   unpacked_repeat_accumulate_buffer #(
      .IN_WIDTH(8), .IN_NUM(2), .REPEAT(2), .SIZE(S)
   ) dut_a (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_valid(in_valid_a), .in_ready(in_ready_a),
      .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a)
   );

   unpacked_repeat_accumulate_buffer #(
      .IN_WIDTH(8), .IN_NUM(2), .REPEAT(3), .SIZE(S)
   ) dut_b (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Offer one beat and wait until it is accepted.
   // Called and returns #1 after a rising edge.
   task automatic drive_beat(input bit sel, input int d0, input int d1);
      bit fired;
      int n;
      if (gaps) begin
         repeat ($urandom_range(0, 1)) begin
            @(posedge clk);
            #1;
         end
      end
      in_data[0] = 8'(d0);
      in_data[1] = 8'(d1);
      if (sel) in_valid_b = 1'b1;
      else     in_valid_a = 1'b1;
      fired = 1'b0;
      n = 0;
      while (!fired && n < 200) begin
         @(negedge clk);
         fired = sel ? in_ready_b : in_ready_a;
         @(posedge clk);
         #1;
         n++;
      end
      in_valid_a = 1'b0;
      in_valid_b = 1'b0;
      if (!fired) check_val("in_timeout", 64'd0, 64'd1);
   endtask

   // Drive nbeats of pat[]. When push is set, the expected sums go to the scoreboard.
   task automatic send_block(input bit sel, input int rep, input bit push, input int nbeats);
      int ow;
      logic [63:0] m;
      logic [63:0] e;
      int s0;
      int s1;
      ow = sel ? OW_B : OW_A;
      m  = (64'd1 << ow) - 64'd1;
      if (push) begin
         for (int p = 0; p < S; p++) begin
            s0 = 0;
            s1 = 0;
            for (int r = 0; r < rep; r++) begin
               s0 += pat[r*S+p][0];
               s1 += pat[r*S+p][1];
            end
            e = ((64'(s1) & m) << ow) | (64'(s0) & m);
            if (sel) q_b.push_back(e);
            else     q_a.push_back(e);
         end
      end
      for (int b = 0; b < nbeats; b++) begin
         drive_beat(sel, pat[b][0], pat[b][1]);
      end
   endtask

   task automatic wait_drain(input bit sel);
      int n;
      n = 0;
      while ((sel ? q_b.size() : q_a.size()) != 0 && n < 1000) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_val(sel ? "drain_b" : "drain_a", 64'(sel ? q_b.size() : q_a.size()), 64'd0);
   endtask

   task automatic fill(input int v0, input int v1);
      for (int i = 0; i < 12; i++) begin
         pat[i][0] = v0;
         pat[i][1] = v1;
      end
   endtask

   // Output consumer: out_ready is updated just after each rising edge.
   initial begin
      out_ready_a = 1'b1;
      out_ready_b = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_ready_a = hold_rdy ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
         out_ready_b = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Scoreboard monitor: a beat that will transfer on the next rising edge is checked here.
   initial begin
      forever begin
         @(negedge clk);
         if (out_valid_a && out_ready_a) begin
            if (q_a.size() == 0) check_val("a_spurious", 64'd1, 64'd0);
            else check_val("a_beat", 64'({out_data_a[1], out_data_a[0]}), q_a.pop_front());
         end
         if (out_valid_b && out_ready_b) begin
            if (q_b.size() == 0) check_val("b_spurious", 64'd1, 64'd0);
            else check_val("b_beat", 64'({out_data_b[1], out_data_b[0]}), q_b.pop_front());
         end
      end
   end

   initial begin
      logic [17:0] snap;
      rst        = 1'b1;
      in_valid_a = 1'b0;
      in_valid_b = 1'b0;
      in_data[0] = 8'd0;
      in_data[1] = 8'd0;
      gaps       = 1'b0;
      rand_rdy   = 1'b0;
      hold_rdy   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_in_ready_a",  64'(in_ready_a),  64'd0);
      check_val("rst_out_valid_a", 64'(out_valid_a), 64'd0);
      check_val("rst_in_ready_b",  64'(in_ready_b),  64'd0);
      check_val("rst_out_valid_b", 64'(out_valid_b), 64'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_val("ready_after_rst", 64'(in_ready_a), 64'd1);

      // Basic sum; out_valid is set right at the edge of the 8th transfer.
      for (int i = 0; i < 8; i++) begin
         pat[i][0] = 2*(i%S) + 1;
         pat[i][1] = 2*(i%S) + 2;
      end
      send_block(1'b0, 2, 1'b1, 7);
      check_val("ovalid_low_before_last", 64'(out_valid_a), 64'd0);
      drive_beat(1'b0, pat[7][0], pat[7][1]);
      check_val("ovalid_rise", 64'(out_valid_a), 64'd1);
      check_val("in_ready_drain", 64'(in_ready_a), 64'd0);
      wait_drain(1'b0);

      // Sign extension: -128 + -128 = -256, which is 9'h100.
      fill(-128, -128);
      send_block(1'b0, 2, 1'b1, 8);
      wait_drain(1'b0);

      // Backpressure: hold out_ready low for 5 cycles while draining.
      hold_rdy = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         pat[i][0] = 10*(i%S) + i/S - 7;
         pat[i][1] = -3*(i%S) + 20*(i/S);
      end
      send_block(1'b0, 2, 1'b1, 8);
      snap = {out_data_a[1], out_data_a[0]};
      repeat (5) begin
         @(posedge clk);
         #1;
         check_val("bp_stable",    64'({out_data_a[1], out_data_a[0]}), 64'(snap));
         check_val("bp_in_ready",  64'(in_ready_a),  64'd0);
         check_val("bp_out_valid", 64'(out_valid_a), 64'd1);
      end
      hold_rdy = 1'b0;
      wait_drain(1'b0);

      // Back-to-back blocks: all 1s, then all 3s.
      fill(1, 1);
      send_block(1'b0, 2, 1'b1, 8);
      fill(3, 3);
      send_block(1'b0, 2, 1'b1, 8);
      wait_drain(1'b0);

      // Reset after 2 beats of pass 1: the partial block is discarded.
      fill(7, -7);
      send_block(1'b0, 2, 1'b0, 6);
      rst = 1'b1;
      #1;
      check_val("midrst_out_valid", 64'(out_valid_a), 64'd0);
      check_val("midrst_in_ready",  64'(in_ready_a),  64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      fill(5, 5);
      send_block(1'b0, 2, 1'b1, 8);
      wait_drain(1'b0);

      // REPEAT=3 with random input gaps and random out_ready, 20 blocks.
      gaps     = 1'b1;
      rand_rdy = 1'b1;
      for (int blk = 0; blk < 20; blk++) begin
         for (int i = 0; i < 12; i++) begin
            pat[i][0] = int'($urandom_range(0, 255)) - 128;
            pat[i][1] = int'($urandom_range(0, 255)) - 128;
         end
         send_block(1'b1, 3, 1'b1, 12);
      end
      wait_drain(1'b1);
      check_val("a_idle", 64'(out_valid_a), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
